proc_apb_master: RTL and testbench
==================================

PROC_APB_MASTER -- requirements
Module: proc_apb_master

Interface
REQ-001 Parameter TIMEOUT, default 8'd64, max ACCESS cycles waiting for ready before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk.
REQ-004 start  input  1  processor request strobe; sampled only in IDLE.
REQ-005 write  input  1  1 = write, 0 = read.
REQ-006 sel  input  2  target slave id; 2'b00 = no slave (invalid).
REQ-007 addr / wdata / wait_cycles  input  8 each  request address, write data, wait cycles forwarded to the slave.
REQ-008 rdata  output  8  read result, or 8'hFF on error.
REQ-009 stable  output  1  one-cycle completion pulse; rdata and error valid while high.
REQ-010 error  output  1  high with stable when the transfer aborted (invalid sel, no id match, timeout).
REQ-011 id1, id2  input  2 each  ids of slave ports 1 and 2.
REQ-012 apb_write, apb_enable  output  1 each  APB write and enable.
REQ-013 apb_sel  output  2  APB select; 2'b00 when idle.
REQ-014 apb_addr, apb_wdata, apb_wait_cycles  output  8 each  APB address, write data, wait cycles.
REQ-015 ready1, ready2  input  1 each  slave ready, port 1 and 2.
REQ-016 rdata1, rdata2  input  8 each  slave read data, port 1 and 2.

Function
REQ-017 FSM states IDLE, SETUP, ACCESS, DONE; encoding is an enum from the shared package.
REQ-018 IDLE: start=1 and sel matches id1 or id2 -> capture write/sel/addr/wdata/wait_cycles into registers, go SETUP.
REQ-019 IDLE: start=1 and sel=00 or matches neither id -> go DONE with error=1, rdata=8'hFF; no APB activity.
REQ-020 SETUP (exactly one cycle): apb_sel/addr/wdata/write/wait_cycles from captured registers, apb_enable=0; go ACCESS.
REQ-021 ACCESS: APB outputs held, apb_enable=1; the selected ready/rdata is from port 1 if captured sel==id1, else port 2; port 1 wins if id1==id2.
REQ-022 ACCESS with selected ready=1 at clock edge -> go DONE; reads latch selected rdata; writes leave rdata unchanged.
REQ-023 ACCESS cycles counted from 1; if count reaches TIMEOUT with ready still 0 -> go DONE with error=1, rdata=8'hFF.
REQ-024 DONE (exactly one cycle): stable=1, apb_sel=00, apb_enable=0; go IDLE.
REQ-025 Zero-wait latency: start sampled at edge N -> SETUP cycle N+1, ACCESS N+2, stable high in cycle N+3.
REQ-026 start during SETUP/ACCESS/DONE is ignored and not queued; processor input changes after capture do not affect the transfer in flight.
REQ-027 Back-to-back: start in the IDLE cycle immediately after DONE is accepted.
REQ-028 error cleared to 0 on every accepted start; rdata holds its last value between transfers.
REQ-029 Ready on the non-selected port is ignored in all states.

Reset
REQ-030 reset=0 forces state IDLE immediately, independent of clk, including mid-transfer.
REQ-031 Reset values: apb_sel=00, apb_enable=0, apb_write=0, apb_addr/apb_wdata/apb_wait_cycles=0, rdata=0, stable=0, error=0, timeout count 0.
REQ-032 An in-flight transfer aborted by reset produces no stable pulse.

Structure
REQ-033 Shared package apb_pkg holds: state enum, SEL_NONE=2'b00, ERR_DATA=8'hFF, default TIMEOUT.
REQ-034 One sub-module apb_timeout_counter: clear/enable inputs, expired output, parameter TIMEOUT.

Verification
REQ-035 id1=1, id2=2; read sel=1 addr=8'h10, ready1 high in first ACCESS, rdata1=8'hA5 -> stable at N+3, rdata=A5, error=0.
REQ-036 Write sel=2 wdata=8'h3C wait_cycles=3, ready2 high after 3 ACCESS cycles -> apb_enable high 4 cycles, apb_wdata=3C throughout, stable at N+6.
REQ-037 start with sel=0, then sel=3 with no matching id -> no apb_sel activity; stable+error one cycle after start; rdata=FF.
REQ-038 TIMEOUT=4, ready held 0 -> exactly 4 ACCESS cycles, then stable+error, rdata=FF, apb_sel returns 00.
REQ-039 reset driven low during ACCESS, between edges -> all outputs to reset values at once, no stable pulse; the next start completes normally.
REQ-040 start held high continuously, ready1 always 1 -> back-to-back transfers, one stable per 4 cycles, no start accepted outside IDLE.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the processor-to-APB master.
// Contents: FSM state encoding, the "no slave" select code, the data
// value returned on an aborted transfer and the default ACCESS timeout.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } apb_state_t;

   localparam logic [1:0] SEL_NONE        = 2'b00;
   localparam logic [7:0] ERR_DATA        = 8'hFF;
   localparam logic [7:0] TIMEOUT_DEFAULT = 8'd64;

endpackage

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase watchdog for proc_apb_master.
// Ports:
//   clk_i      - clock, rising edge
//   reset_ni   - asynchronous active-low reset
//   clear_i    - synchronous clear, wins over enable
//   enable_i   - count one ACCESS cycle per clock
//   expired_o  - high while enabled in the TIMEOUT-th ACCESS cycle or later
module apb_timeout_counter
   import apb_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   // cnt_q holds the number of ACCESS cycles already completed, so the
   // current ACCESS cycle number is cnt_q + 1.
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = 8'd0;
      end else if (enable_i && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Widened compare so the +1 cannot wrap at 8'hFF.
   assign expired_o = enable_i && (({1'b0, cnt_q} + 9'd1) >= {1'b0, TIMEOUT});

endmodule

// File: rtl/proc_apb_master.sv
// Processor request to two-port APB master bridge.
// A request strobed in IDLE is checked against the two slave ids, captured,
// and run as SETUP (one cycle) then ACCESS (until the selected ready or a
// timeout), ending in a one-cycle DONE where stable pulses.
// Handshake: a slave port completes ACCESS when its ready is high at the
// rising edge while apb_enable is high; ready from the other port is ignored.
// Ports:
//   clk, reset (async active-low)
//   start/write/sel/addr/wdata/wait_cycles - processor request
//   rdata/stable/error                     - processor result
//   id1/id2, ready1/ready2, rdata1/rdata2   - slave port ids and responses
//   apb_write/apb_enable/apb_sel/apb_addr/apb_wdata/apb_wait_cycles - APB
//   dbg_state                              - current FSM state
module proc_apb_master
   import apb_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       write,
   input  logic [1:0] sel,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic [7:0] wait_cycles,
   output logic [7:0] rdata,
   output logic       stable,
   output logic       error,
   input  logic [1:0] id1,
   input  logic [1:0] id2,
   output logic       apb_write,
   output logic       apb_enable,
   output logic [1:0] apb_sel,
   output logic [7:0] apb_addr,
   output logic [7:0] apb_wdata,
   output logic [7:0] apb_wait_cycles,
   input  logic       ready1,
   input  logic       ready2,
   input  logic [7:0] rdata1,
   input  logic [7:0] rdata2,
   output logic [1:0] dbg_state
);

   apb_state_t state_q, state_d;
   logic       write_q, write_d;
   logic [1:0] sel_q, sel_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] wait_q, wait_d;
   logic [7:0] rdata_q, rdata_d;
   logic       error_q, error_d;

   logic       sel_valid;
   logic       use_port1;
   logic       sel_ready;
   logic [7:0] sel_rdata;
   logic       expired;

   assign sel_valid = (sel != SEL_NONE) && ((sel == id1) || (sel == id2));

   // Port 1 is checked first, so it wins when both ids are equal.
   assign use_port1 = (sel_q == id1);
   assign sel_ready = use_port1 ? ready1 : ready2;
   assign sel_rdata = use_port1 ? rdata1 : rdata2;

   apb_timeout_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i     (clk),
      .reset_ni  (reset),
      .clear_i   (state_q != ST_ACCESS),
      .enable_i  (state_q == ST_ACCESS),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wait_d  = wait_q;
      rdata_d = rdata_q;
      error_d = error_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (sel_valid) begin
                  write_d = write;
                  sel_d   = sel;
                  addr_d  = addr;
                  wdata_d = wdata;
                  wait_d  = wait_cycles;
                  error_d = 1'b0;
                  state_d = ST_SETUP;
               end else begin
                  // Rejected without touching the APB side.
                  error_d = 1'b1;
                  rdata_d = ERR_DATA;
                  state_d = ST_DONE;
               end
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            // A ready in the last allowed cycle still completes normally.
            if (sel_ready) begin
               if (!write_q) begin
                  rdata_d = sel_rdata;
               end
               state_d = ST_DONE;
            end else if (expired) begin
               error_d = 1'b1;
               rdata_d = ERR_DATA;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         sel_q   <= SEL_NONE;
         addr_q  <= 8'd0;
         wdata_q <= 8'd0;
         wait_q  <= 8'd0;
         rdata_q <= 8'd0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wait_q  <= wait_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   assign apb_sel         = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? sel_q : SEL_NONE;
   assign apb_enable      = (state_q == ST_ACCESS);
   assign apb_write       = write_q;
   assign apb_addr        = addr_q;
   assign apb_wdata       = wdata_q;
   assign apb_wait_cycles = wait_q;
   assign stable          = (state_q == ST_DONE);
   assign error           = error_q;
   assign rdata           = rdata_q;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_proc_apb_master.sv
module tb_proc_apb_master;

   logic       clk;
   logic       reset;
   logic       start;
   logic       write;
   logic [1:0] sel;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] wait_cycles;
   logic [7:0] rdata;
   logic       stable;
   logic       error;
   logic [1:0] id1;
   logic [1:0] id2;
   logic       apb_write;
   logic       apb_enable;
   logic [1:0] apb_sel;
   logic [7:0] apb_addr;
   logic [7:0] apb_wdata;
   logic [7:0] apb_wait_cycles;
   logic       ready1;
   logic       ready2;
   logic [7:0] rdata1;
   logic [7:0] rdata2;
   logic [1:0] dbg_state;

   int n_chk = 0;
   int n_bad = 0;

   // Slave model: completes after apb_wait_cycles extra ACCESS cycles.
   logic [7:0] acc_cnt;
   logic       noise1, noise2;

   proc_apb_master #(.TIMEOUT(8'd4)) dut (
      .clk(clk), .reset(reset), .start(start), .write(write), .sel(sel),
      .addr(addr), .wdata(wdata), .wait_cycles(wait_cycles),
      .rdata(rdata), .stable(stable), .error(error),
      .id1(id1), .id2(id2),
      .apb_write(apb_write), .apb_enable(apb_enable), .apb_sel(apb_sel),
      .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_wait_cycles(apb_wait_cycles),
      .ready1(ready1), .ready2(ready2), .rdata1(rdata1), .rdata2(rdata2),
      .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!apb_enable) acc_cnt <= 8'd0;
      else if (acc_cnt != 8'hFF) acc_cnt <= acc_cnt + 8'd1;
   end

   assign ready1 = noise1 | (apb_enable && (apb_sel == id1) && (acc_cnt >= apb_wait_cycles));
   assign ready2 = noise2 | (apb_enable && (apb_sel == id2) && (apb_sel != id1) &&
                             (acc_cnt >= apb_wait_cycles));

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       wr;
      logic [1:0] sel;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] wt;
      logic [7:0] rd1;
      logic [7:0] rd2;
      logic       nz1;
      logic       nz2;
      int         lat;
      logic [7:0] exp_rd;
      logic       exp_err;
      int         exp_en;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_xfer(input vec_t v, input string tag);
      int cyc;
      int en;
      int selact;
      int hold_bad;
      bit got;
      @(negedge clk);
      start = 1'b1; write = v.wr; sel = v.sel; addr = v.addr; wdata = v.wdata;
      wait_cycles = v.wt; rdata1 = v.rd1; rdata2 = v.rd2; noise1 = v.nz1; noise2 = v.nz2;
      @(negedge clk);
      // Inputs change after capture; the transfer must not see this.
      start = 1'b0; write = ~v.wr; addr = ~v.addr; wdata = ~v.wdata; wait_cycles = 8'd0;
      cyc = 1; en = 0; selact = 0; hold_bad = 0; got = 0;
      while (cyc <= 40) begin
         if (apb_enable) begin
            en++;
            if ({apb_addr, apb_wdata, apb_write, apb_sel, apb_wait_cycles} !==
                {v.addr, v.wdata, v.wr, v.sel, v.wt}) hold_bad++;
         end
         if (apb_sel != 2'b00) selact++;
         if (stable) begin
            got = 1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, got ? 64'(cyc) : 64'd999, 64'(v.lat));
      check({tag, " rdata"}, 64'(rdata), 64'(v.exp_rd));
      check({tag, " error"}, 64'(error), 64'(v.exp_err));
      check({tag, " enable_cycles"}, 64'(en), 64'(v.exp_en));
      check({tag, " sel_cycles"}, 64'(selact), (v.exp_en == 0) ? 64'd0 : 64'(v.exp_en + 1));
      check({tag, " apb_hold"}, 64'(hold_bad), 64'd0);
      @(negedge clk);
      check({tag, " done_one_cycle"}, {62'd0, stable, apb_sel != 2'b00}, 64'd0);
      noise1 = 1'b0; noise2 = 1'b0;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {26'd0, rdata, stable, error, apb_write, apb_enable, apb_sel,
                   apb_addr, apb_wdata, apb_wait_cycles, dbg_state}, 64'd0);
   endtask

   initial begin
      int st_cnt;
      int setup_cnt;
      int last_st;
      int gap_bad;
      vec_t v;

      //          wr    sel    addr   wdata  wt      rd1    rd2    nz1  nz2  lat rd     err  en
      vecs[0] = '{1'b0, 2'd1, 8'h10, 8'h00, 8'd0,   8'hA5, 8'h00, 1'b0, 1'b0, 3, 8'hA5, 1'b0, 1};
      vecs[1] = '{1'b1, 2'd2, 8'h20, 8'h3C, 8'd3,   8'h00, 8'h99, 1'b0, 1'b0, 6, 8'hA5, 1'b0, 4};
      vecs[2] = '{1'b0, 2'd0, 8'h30, 8'h00, 8'd0,   8'h11, 8'h22, 1'b0, 1'b0, 1, 8'hFF, 1'b1, 0};
      vecs[3] = '{1'b0, 2'd3, 8'h31, 8'h00, 8'd0,   8'h11, 8'h22, 1'b0, 1'b0, 1, 8'hFF, 1'b1, 0};
      vecs[4] = '{1'b0, 2'd2, 8'h40, 8'h00, 8'd1,   8'h77, 8'h5A, 1'b1, 1'b0, 4, 8'h5A, 1'b0, 2};
      vecs[5] = '{1'b0, 2'd1, 8'h50, 8'h00, 8'd200, 8'h66, 8'h00, 1'b0, 1'b0, 6, 8'hFF, 1'b1, 4};
      vecs[6] = '{1'b1, 2'd1, 8'h60, 8'hE1, 8'd0,   8'h00, 8'h00, 1'b0, 1'b0, 3, 8'hFF, 1'b0, 1};
      vecs[7] = '{1'b0, 2'd1, 8'h70, 8'h00, 8'd3,   8'hC3, 8'h00, 1'b0, 1'b1, 6, 8'hC3, 1'b0, 4};

      reset = 1'b0; start = 1'b0; write = 1'b0; sel = 2'd0; addr = 8'd0; wdata = 8'd0;
      wait_cycles = 8'd0; id1 = 2'd1; id2 = 2'd2; rdata1 = 8'd0; rdata2 = 8'd0;
      noise1 = 1'b0; noise2 = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_values");
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         do_xfer(vecs[i], $sformatf("vec%0d", i));
      end

      // Equal ids: port 1 must win even with port 2 ready asserted.
      id2 = 2'd1;
      v = '{1'b0, 2'd1, 8'h80, 8'h00, 8'd0, 8'h11, 8'h22, 1'b0, 1'b1, 3, 8'h11, 1'b0, 1};
      do_xfer(v, "same_id");
      id2 = 2'd2;

      // Reset asserted between edges during ACCESS.
      @(negedge clk);
      start = 1'b1; write = 1'b0; sel = 2'd1; addr = 8'h90; wait_cycles = 8'd200;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("midreset in_access", 64'(apb_enable), 64'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("midreset immediate");
      st_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (stable) st_cnt++;
      end
      check("midreset no_stable", 64'(st_cnt), 64'd0);
      reset = 1'b1;
      v = '{1'b0, 2'd2, 8'hA0, 8'h00, 8'd0, 8'h00, 8'hB7, 1'b0, 1'b0, 3, 8'hB7, 1'b0, 1};
      do_xfer(v, "after_reset");

      // start held high: one transfer per 4 cycles, none accepted outside IDLE.
      @(negedge clk);
      start = 1'b1; write = 1'b0; sel = 2'd1; addr = 8'hC0; wait_cycles = 8'd0; rdata1 = 8'h42;
      st_cnt = 0; setup_cnt = 0; last_st = -1; gap_bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (apb_sel != 2'b00 && !apb_enable) setup_cnt++;
         if (stable) begin
            if (last_st >= 0 && (i - last_st) != 4) gap_bad++;
            if (last_st < 0 && i != 2) gap_bad++;
            last_st = i;
            st_cnt++;
         end
      end
      start = 1'b0;
      check("b2b stable_count", 64'(st_cnt), 64'd5);
      check("b2b setup_count", 64'(setup_cnt), 64'd5);
      check("b2b spacing", 64'(gap_bad), 64'd0);
      check("b2b rdata", 64'(rdata), 64'h42);
      repeat (2) @(negedge clk);
      check("b2b idle_after", {62'd0, dbg_state}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
